a_fifo_rd_sched: RTL and testbench
==================================

Name: a_fifo_rd_sched

Overview:
- Read-side burst scheduler for the asynchronous FIFO; lives entirely in the clkb domain.
- Shares the single FIFO read port between NREQ consumers using round-robin arbitration.
- Each grant drains a latched burst length, stalls on empty, and tags every returned word with the consumer index.
- Drives the FIFO rd input; consumes the FIFO dout_clkb and empty outputs.

Parameters:
NREQ, 4, number of consumers (2..8)
DW, 8, data width; matches FIFO word width
BLW, 4, burst-length field width; maximum burst is 2^BLW-1 words
TIMEOUT, 32, stall limit in cycles (used only with the optional feature)

Ports:
clkb  in  1  read-domain clock; all logic on the rising edge
rstb_clkb  in  1  asynchronous active-low reset
req  in  NREQ  per-consumer burst request, level; held until done
req_len  in  NREQ*BLW  packed burst lengths; consumer k uses bits [k*BLW +: BLW]
empty  in  1  FIFO empty flag
dout_clkb  in  DW  FIFO read data; valid the cycle after rd is sampled high
rd  out  1  FIFO read strobe
gnt  out  NREQ  one-hot current grant; all zero when idle
out_valid  out  1  out_data holds a word for consumer out_id
out_data  out  DW  returned word
out_id  out  $clog2(NREQ)  consumer index tagging out_data
done  out  1  one-cycle pulse when a burst ends; gnt is still valid during the pulse
abort  out  1  qualifies done: burst ended before len words were read

Behaviour:
- Reset, asynchronous: state=IDLE; rd, gnt, out_valid, done, abort = 0; out_data, out_id = 0; cnt=0; rr_ptr=NREQ-1 so consumer 0 has first priority.
- Eligible consumer: req[k]=1 and req_len[k]!=0. A request with length 0 is ignored and never granted.
- IDLE:
  - If any consumer is eligible, pick the first one scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register gnt one-hot, latch cnt=req_len[k] and id=k, go to BURST.
  - Grant appears one cycle after req; no rd is issued in the grant cycle.
- BURST:
  - rd = !empty && cnt!=0 && req[id]; rd is combinational from registered state and the current empty.
  - Each cycle with rd=1 decrements cnt.
  - When a read takes cnt from 1 to 0, go to DRAIN.
  - If req[id] falls while cnt!=0, stop reading immediately and go to DRAIN with abort latched.
  - empty=1 stalls with cnt held; gnt stays asserted.
- DRAIN (one cycle): lets the last word return. Assert done (and abort if latched), set rr_ptr=id, go to IDLE. gnt clears on exit.
- Return path:
  - out_valid is rd delayed by one clkb.
  - out_data = dout_clkb (combinational pass-through).
  - out_id is registered alongside out_valid.
  - A burst of L words with no stalls gives L consecutive out_valid cycles, starting 2 cycles after req rises.
- A latched cnt is not affected by req_len changes during a burst.
- A new grant can issue in the cycle after done, so back-to-back bursts are separated by exactly one idle cycle (the IDLE arbitration cycle).
- rd is never asserted while empty=1. This is the scheduler's overflow-safety guarantee and the verifier asserts it every cycle.
- If rstb_clkb is asserted mid-burst, everything returns to reset values immediately. The in-flight word is dropped and no done pulse is produced.

Optional Feature:
- Macro: A_FIFO_RD_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive BURST cycles with empty=1 and cnt!=0; it resets on any rd.
  - When the count reaches TIMEOUT, go to DRAIN with abort=1. The partial word count is already delivered.
  - An extra output, timeout (1 bit), pulses together with done in that case.
- Undefined: no counter and no timeout port; a burst waits on empty indefinitely.

Test Plan:
1. Reset release with FIFO holding 3 words, req=4'b0001, req_len[0]=3 -> gnt=0001 one cycle later; rd high 3 cycles; out_valid 3 cycles with out_id=0 and data in FIFO order; done=1, abort=0.
2. req=4'b1111, all lengths 2, FIFO pre-filled with 8 words -> grants in order 0,1,2,3; each gives 2 words; exactly one idle cycle between bursts; rr_ptr ends at 3.
3. Burst len 5 with empty toggling on alternate cycles -> rd only in cycles where empty=0; total of 5 out_valid; never rd while empty=1.
4. Consumer 2 granted len 6, req[2] dropped after 2 reads -> rd stops the same cycle; 2 words delivered; done=1, abort=1; next grant goes to 3 if it is requesting.
5. req[1]=1 with req_len[1]=0, others idle -> no grant, rd stays 0; then len=1 -> grant, 1 word returned.
6. With A_FIFO_RD_SCHED_TIMEOUT_EN and TIMEOUT=32: len 4, 1 word available then empty held -> after 32 stall cycles, done, abort and timeout all pulse, with 1 word delivered. Also assert rstb_clkb low mid-burst and confirm all outputs return to zero asynchronously.

Source files
------------

// File: rtl/a_fifo_rd_sched.sv
// Round-robin burst scheduler sharing the async FIFO read port among NREQ consumers (clkb domain).
// Define A_FIFO_RD_SCHED_TIMEOUT_EN to abort bursts that stall on empty for TIMEOUT cycles.
module a_fifo_rd_sched #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int BLW     = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                    clkb,
    input  logic                    rstb_clkb,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*BLW-1:0]     req_len,
    input  logic                    empty,
    input  logic [DW-1:0]           dout_clkb,
    output logic                    rd,
    output logic [NREQ-1:0]         gnt,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    done,
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
    output logic                    timeout,
`endif
    output logic                    abort
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_params
        $error("a_fifo_rd_sched: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [NREQ-1:0]           gnt_q, gnt_d;
    logic [BLW-1:0]            cnt_q, cnt_d;
    logic [IDW-1:0]            id_q, id_d, rr_ptr_q, rr_ptr_d, out_id_q, out_id_d;
    logic                      done_q, done_d, abort_q, abort_d, out_valid_q, out_valid_d;
    logic [NREQ-1:0][BLW-1:0]  len_a;
    logic [NREQ-1:0]           elig;
    logic [IDW-1:0]            pick;
    logic                      found;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0]             stall_q, stall_d;
    logic                      timeout_q, timeout_d;
`endif

    assign len_a = req_len;

    // Zero-length requests are never eligible, so they can never win arbitration.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NREQ; k++) elig[k] = req[k] && (len_a[k] != '0);
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((32'(rr_ptr_q) + i) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        rd        = 1'b0;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
        stall_d   = stall_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    gnt_d   = NREQ'(1) << pick;
                    cnt_d   = len_a[pick];
                    id_d    = pick;
                end
            end
            BURST: begin
                rd = !empty && (cnt_q != '0) && req[id_q];
                if (rd) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == BLW'(1)) begin
                        state_d = DRAIN;
                        done_d  = 1'b1;
                    end
                end else if (!req[id_q]) begin
                    state_d = DRAIN;
                    done_d  = 1'b1;
                    abort_d = 1'b1;
                end
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
                if (rd) stall_d = '0;
                else if (empty && cnt_q != '0) stall_d = stall_q + 1'b1;
                // This cycle is the TIMEOUT-th consecutive stall.
                if (!rd && req[id_q] && empty && cnt_q != '0 && stall_q == SW'(TIMEOUT - 1)) begin
                    state_d   = DRAIN;
                    done_d    = 1'b1;
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            DRAIN: begin
                state_d  = IDLE;
                gnt_d    = '0;
                rr_ptr_d = id_q;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
                stall_d  = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = rd;
        out_id_d    = rd ? id_q : out_id_q;
    end

    always_ff @(posedge clkb or negedge rstb_clkb) begin
        if (!rstb_clkb) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
            stall_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
            stall_q     <= stall_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? dout_clkb : '0;
    assign out_id    = out_id_q;
    assign done      = done_q;
    assign abort     = abort_q;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_a_fifo_rd_sched.sv
// Bench for a_fifo_rd_sched: FIFO model, scoreboard of expected {id,data} words, vector table plus corner sequences.
module tb_a_fifo_rd_sched;

    logic        clkb = 1'b0;
    logic        rstb_clkb = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_len = '0;
    logic        force_empty = 1'b0;
    logic        empty;
    logic [7:0]  dout_clkb = '0;
    logic        rd, out_valid, done, abort;
    logic [3:0]  gnt;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clkb = ~clkb;

    a_fifo_rd_sched #(.NREQ(4), .DW(8), .BLW(4), .TIMEOUT(32)) dut (
        .clkb(clkb), .rstb_clkb(rstb_clkb), .req(req), .req_len(req_len),
        .empty(empty), .dout_clkb(dout_clkb), .rd(rd), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
        .done(done),
`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
        .timeout(timeout),
`endif
        .abort(abort)
    );

    // FIFO model: data appears on dout_clkb the cycle after rd is sampled.
    logic [7:0] mem [0:255];
    int wptr = 0;
    int rptr = 0;
    assign empty = force_empty || (wptr == rptr);
    always @(posedge clkb) if (rd) begin
        dout_clkb <= mem[rptr[7:0]];
        rptr <= rptr + 1;
    end

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        int          nwords;
        logic [3:0]  exp_gnt;
        int          exp_id;
    } vec_t;

    int total = 0, bad = 0, cycle = 0;
    int n_valid = 0, n_rd = 0, n_done = 0, n_abort = 0, last_done = 0;
    logic [7:0]  wd = 8'h10;
    logic [15:0] sb [$];
    logic [3:0]  glog [$];
    int          gaps [$];
    logic [3:0]  prev_gnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic mon();
        logic [15:0] e;
        cycle++;
        if (out_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got id=%0d data=0x%0h expected none", out_id, out_data);
            end else begin
                e = sb.pop_front();
                chk("out_word", {16'b0, 6'b0, out_id, out_data}, {16'b0, e});
            end
        end
        if (done) begin
            n_done++;
            last_done = cycle;
            if (abort) n_abort++;
        end
        if (gnt != 0 && prev_gnt == 0) begin
            glog.push_back(gnt);
            gaps.push_back(cycle - last_done);
        end
        prev_gnt = gnt;
    endtask

    // Called right after stimulus is set at a negedge; rd is checked just before the sampling edge.
    task automatic cyc();
        #3;
        if (rd) begin
            n_rd++;
            chk("rd_while_empty", {31'b0, empty}, 0);
        end
        @(negedge clkb);
        mon();
    endtask

    task automatic fill(input int n, input int id, input bit push);
        for (int i = 0; i < n; i++) begin
            mem[wptr[7:0]] = wd;
            if (push) sb.push_back({8'(id), wd});
            wptr++;
            wd++;
        end
    endtask

    task automatic wait_done(input int max, input string name);
        bit seen;
        seen = done;
        for (int i = 0; i < max && !seen; i++) begin
            cyc();
            seen = done;
        end
        chk({name, "_done_seen"}, {31'b0, seen}, 1);
    endtask

    initial begin
        vec_t vecs [4];
        int   nv0, nr0, nd0, na0, g0, gc;
        vecs[0] = '{4'b0001, 16'h0003, 3,  4'b0001, 0};
        vecs[1] = '{4'b0010, 16'h0010, 1,  4'b0010, 1};
        vecs[2] = '{4'b0100, 16'h17A0, 7,  4'b0100, 2};
        vecs[3] = '{4'b1000, 16'hF000, 15, 4'b1000, 3};

        repeat (2) @(negedge clkb);
        rstb_clkb = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rd", rd, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done_abort", {done, abort}, 0);
        chk("rst_out_data_id", {out_id, out_data}, 0);
        cyc();
        chk("idle_gnt", gnt, 0);

        // Single-consumer bursts, one per table row.
        foreach (vecs[v]) begin
            fill(vecs[v].nwords, vecs[v].exp_id, 1'b1);
            req = vecs[v].req;
            req_len = vecs[v].len;
            nv0 = n_valid;
            #1 chk("vec_arb_no_rd", rd, 0);
            cyc();
            chk("vec_gnt", gnt, vecs[v].exp_gnt);
            chk("vec_valid_not_yet", out_valid, 0);
            cyc();
            chk("vec_first_valid", out_valid, 1);
            wait_done(40, "vec");
            chk("vec_abort", abort, 0);
            chk("vec_words", n_valid - nv0, vecs[v].nwords);
            chk("vec_sb_empty", sb.size(), 0);
            req = '0;
            cyc();
            chk("vec_gnt_clear", gnt, 0);
        end

        // All four requesting, length 2 each: expect order 0,1,2,3 with one idle cycle between.
        for (int k = 0; k < 4; k++) fill(2, k, 1'b1);
        req = 4'b1111;
        req_len = 16'h2222;
        nv0 = n_valid; na0 = n_abort; g0 = glog.size(); gc = 0;
        for (int i = 0; i < 100 && gc < 4; i++) begin
            cyc();
            if (done) begin
                req[gc] = 1'b0;
                gc++;
            end
        end
        chk("rr_bursts", gc, 4);
        chk("rr_grants", glog.size() - g0, 4);
        for (int k = 0; k < 4 && g0 + k < glog.size(); k++) begin
            chk("rr_order", glog[g0 + k], 32'(1) << k);
            if (k > 0) chk("rr_gap", gaps[g0 + k], 2);
        end
        chk("rr_words", n_valid - nv0, 8);
        chk("rr_no_abort", n_abort - na0, 0);
        chk("rr_sb_empty", sb.size(), 0);
        cyc();

        // Consumer 0 must win over 3 (pointer left at 3); empty toggles; len change mid-burst ignored.
        fill(5, 0, 1'b1);
        req = 4'b1001;
        req_len = 16'h1005;
        nv0 = n_valid; nr0 = n_rd;
        cyc();
        chk("t3_gnt", gnt, 4'b0001);
        req = 4'b0001;
        req_len = 16'h0001;
        for (int i = 0; i < 60 && !done; i++) begin
            force_empty = ~force_empty;
            cyc();
        end
        chk("t3_done", done, 1);
        chk("t3_abort", abort, 0);
        chk("t3_reads", n_rd - nr0, 5);
        chk("t3_words", n_valid - nv0, 5);
        force_empty = 1'b0;
        req = '0;
        cyc();

        // Consumer 2 drops its request after two reads; consumer 3 is served next.
        fill(2, 2, 1'b1);
        fill(2, 3, 1'b1);
        fill(2, 0, 1'b0);
        req = 4'b1100;
        req_len = 16'h2600;
        nv0 = n_valid;
        cyc();
        chk("t4_gnt", gnt, 4'b0100);
        cyc();
        cyc();
        req = 4'b1000;
        #1 chk("t4_rd_stop", rd, 0);
        cyc();
        chk("t4_done", done, 1);
        chk("t4_abort", abort, 1);
        chk("t4_words", n_valid - nv0, 2);
        cyc();
        chk("t4_idle", gnt, 0);
        cyc();
        chk("t4_next_gnt", gnt, 4'b1000);
        wait_done(20, "t4b");
        chk("t4b_abort", abort, 0);
        chk("t4_sb_empty", sb.size(), 0);
        req = '0;
        cyc();
        wptr = rptr;

        // Zero length is never granted; length 1 then is.
        fill(1, 1, 1'b1);
        req = 4'b0010;
        req_len = 16'h0000;
        repeat (4) begin
            cyc();
            chk("t5_no_gnt", gnt, 0);
            chk("t5_no_rd", rd, 0);
        end
        req_len = 16'h0010;
        cyc();
        chk("t5_gnt", gnt, 4'b0010);
        wait_done(10, "t5");
        chk("t5_abort", abort, 0);
        chk("t5_sb_empty", sb.size(), 0);
        req = '0;
        cyc();

        // Asynchronous reset mid-burst: one word delivered, in-flight read dropped, no done.
        fill(1, 0, 1'b1);
        fill(3, 0, 1'b0);
        req = 4'b0001;
        req_len = 16'h0004;
        nd0 = n_done;
        cyc();
        chk("t6_gnt", gnt, 4'b0001);
        cyc();
        chk("t6_valid", out_valid, 1);
        #2 rstb_clkb = 1'b0;
        #1;
        chk("t6_rst_rd", rd, 0);
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_done_abort", {done, abort}, 0);
        chk("t6_rst_data_id", {out_id, out_data}, 0);
        req = '0;
        @(negedge clkb);
        rstb_clkb = 1'b1;
        wptr = rptr;
        repeat (3) cyc();
        chk("t6_no_done", n_done - nd0, 0);
        chk("t6_gnt_idle", gnt, 0);
        chk("t6_sb_empty", sb.size(), 0);

`ifdef A_FIFO_RD_SCHED_TIMEOUT_EN
        // One word available, then empty forever: timeout after 32 stall cycles.
        fill(1, 0, 1'b1);
        req = 4'b0001;
        req_len = 16'h0004;
        nv0 = n_valid;
        cyc();
        chk("t7_gnt", gnt, 4'b0001);
        gc = cycle;
        wait_done(60, "t7");
        chk("t7_latency", cycle - gc, 33);
        chk("t7_abort", abort, 1);
        chk("t7_timeout", timeout, 1);
        chk("t7_words", n_valid - nv0, 1);
        chk("t7_sb_empty", sb.size(), 0);
        req = '0;
        cyc();
        chk("t7_timeout_clear", timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
